// File: rtl/mem_ctrl_arbiter_if.sv
// mem_ctrl_arbiter_if: one block-memory request/response channel.
// The master drives requests and receives responses; the slave accepts
// requests and returns responses. The same channel type serves the icache
// port, the dcache port and the memory-controller port of the arbiter.

`ifndef MAIN_MEM_BLOCK_ADDR_WIDTH
`define MAIN_MEM_BLOCK_ADDR_WIDTH 26
`endif
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 512
`endif

interface mem_ctrl_arbiter_if #(
    parameter int ADDR_W = `MAIN_MEM_BLOCK_ADDR_WIDTH,
    parameter int DATA_W = `BLOCK_DATA_WIDTH
);
    logic              req_valid;
    logic              req_type;        // 0 read, 1 write
    logic [ADDR_W-1:0] req_block_addr;
    logic [DATA_W-1:0] req_block_data;
    logic              req_ready;
    logic              resp_valid;      // read data or write ack, 1-cycle pulse
    logic [DATA_W-1:0] resp_block_data;

    modport master (
        output req_valid, req_type, req_block_addr, req_block_data,
        input  req_ready, resp_valid, resp_block_data
    );

    modport slave (
        input  req_valid, req_type, req_block_addr, req_block_data,
        output req_ready, resp_valid, resp_block_data
    );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter: shares the single memory-controller port between the
// icache (read-only block fills) and the dcache (block reads/writebacks).
// One transaction is outstanding at a time; its response is routed back to
// the requester that owns it.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// conflicts; without it the dcache has fixed priority.

`ifndef MAIN_MEM_BLOCK_ADDR_WIDTH
`define MAIN_MEM_BLOCK_ADDR_WIDTH 26
`endif
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 512
`endif

module mem_ctrl_arbiter #(
    parameter int ADDR_W = `MAIN_MEM_BLOCK_ADDR_WIDTH,
    parameter int DATA_W = `BLOCK_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst_aL,
    mem_ctrl_arbiter_if.slave  icache,
    mem_ctrl_arbiter_if.slave  dcache,
    mem_ctrl_arbiter_if.master mem
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic              req_type_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;
    logic              grant_i, grant_d;
    logic              accept_i, accept_d;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant_q;

    // Round-robin: on a conflict serve the requester not granted last time.
    always_comb begin
        grant_d = dcache.req_valid && !(icache.req_valid && last_grant_q == OWN_D);
        grant_i = icache.req_valid && !grant_d;
    end

    // Track the most recent winner; reset to D so the first conflict goes to I.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL)       last_grant_q <= OWN_D;
        else if (accept_d) last_grant_q <= OWN_D;
        else if (accept_i) last_grant_q <= OWN_I;
    end
`else
    // Fixed priority: the dcache always wins a conflict.
    always_comb begin
        grant_d = dcache.req_valid;
        grant_i = icache.req_valid && !dcache.req_valid;
    end
`endif

    // FSM next state plus all handshake outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would infer a latch.
        state_d                = state_q;
        accept_i               = 1'b0;
        accept_d               = 1'b0;
        icache.req_ready       = 1'b0;
        dcache.req_ready       = 1'b0;
        icache.resp_valid      = 1'b0;
        dcache.resp_valid      = 1'b0;
        icache.resp_block_data = '0;
        dcache.resp_block_data = '0;
        mem.req_valid          = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gated by reset so no ready is offered while held in reset.
                accept_i         = grant_i && rst_aL;
                accept_d         = grant_d && rst_aL;
                icache.req_ready = accept_i;
                dcache.req_ready = accept_d;
                if (accept_i || accept_d) state_d = ISSUE;
            end
            ISSUE: begin
                mem.req_valid = 1'b1;
                if (mem.req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem.resp_valid) begin
                    state_d = IDLE;
                    if (owner_q == OWN_I) begin
                        icache.resp_valid      = 1'b1;
                        icache.resp_block_data = mem.resp_block_data;
                    end else begin
                        dcache.resp_valid      = 1'b1;
                        dcache.resp_block_data = mem.resp_block_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_aL) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (!rst_aL) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Latch the accepted request; icache fills are always reads with zero data.
    always_ff @(posedge clk or negedge rst_aL) begin
        // NOTE: the datapath registers are reset as well because they drive
        // the memory port directly and must read as zero out of reset.
        if (!rst_aL) begin
            owner_q    <= OWN_I;
            req_type_q <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
        end else if (accept_d) begin
            owner_q    <= OWN_D;
            req_type_q <= dcache.req_type;
            req_addr_q <= dcache.req_block_addr;
            req_data_q <= dcache.req_block_data;
        end else if (accept_i) begin
            owner_q    <= OWN_I;
            req_type_q <= 1'b0;
            req_addr_q <= icache.req_block_addr;
            req_data_q <= '0;
        end
    end

    assign mem.req_type       = req_type_q;
    assign mem.req_block_addr = req_addr_q;
    assign mem.req_block_data = req_data_q;

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// tb_mem_ctrl_arbiter: randomized and directed checks of mem_ctrl_arbiter
// against a transaction-level reference model (request queues, one
// outstanding transaction, rule-based winner choice, block store).

module tb_mem_ctrl_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef struct {
        bit    is_d;
        logic  wr;
        addr_t addr;
        data_t data;
    } txn_t;

    logic clk    = 1'b0;
    logic rst_aL = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) icache ();
    mem_ctrl_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dcache ();
    mem_ctrl_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

    mem_ctrl_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .icache (icache),
        .dcache (dcache),
        .mem    (mem)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    addr_t i_q[$];
    txn_t  d_q[$];
    data_t store [addr_t];
    bit    i_held, d_held;
    bit    outstanding, mem_acc;
    bit    last_d = 1'b1;
    txn_t  cur;
    int    stall_left, lat_left;

    // Stimulus knobs (-1 means random per transaction).
    int pres_pct  = 100;
    int stall_cfg = 0;
    int lat_cfg   = 1;
    int spur_pct  = 0;
    bit force_spur;
    bit rst_hold;

    // Observations of the DUT.
    int cyc;
    int obs_cyc[$];
    bit obs_d[$];
    int mv_seen, ir_seen, iresp_seen, dresp_seen, last_iresp_cyc;

    function automatic data_t mem_read(input addr_t a);
        if (store.exists(a)) return store[a];
        return {a, ~a, a, ~a};
    endfunction

    task automatic model_reset();
        outstanding = 1'b0;
        mem_acc     = 1'b0;
        last_d      = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs at negedge, advance model.
    task automatic tick(input string tn);
        bit    i_vld, d_vld, exp_mv, m_rdy, real_resp, spur, win_d, exp_ir, exp_dr;
        bit    exp_iresp, exp_dresp;
        data_t rdata;
        logic  exp_type;
        addr_t exp_addr;
        data_t exp_data;

        rst_aL = !rst_hold;
        if (rst_hold) model_reset();

        i_vld = (i_q.size() > 0) && (i_held || $urandom_range(0, 99) < pres_pct);
        d_vld = (d_q.size() > 0) && (d_held || $urandom_range(0, 99) < pres_pct);

        icache.req_valid      = i_vld;
        icache.req_type       = 1'($urandom_range(0, 1));
        icache.req_block_addr = i_vld ? i_q[0] : addr_t'($urandom);
        icache.req_block_data = {$urandom, $urandom};
        dcache.req_valid      = d_vld;
        dcache.req_type       = d_vld ? d_q[0].wr : 1'($urandom_range(0, 1));
        dcache.req_block_addr = d_vld ? d_q[0].addr : addr_t'($urandom);
        dcache.req_block_data = d_vld ? d_q[0].data : {$urandom, $urandom};

        exp_mv        = outstanding && !mem_acc;
        m_rdy         = exp_mv && stall_left == 0;
        mem.req_ready = exp_mv ? m_rdy : 1'($urandom_range(0, 1));
        real_resp     = mem_acc && lat_left == 0;
        spur          = !mem_acc && (force_spur || $urandom_range(0, 99) < spur_pct);
        force_spur    = 1'b0;
        rdata         = (real_resp && !cur.wr) ? mem_read(cur.addr) : {$urandom, $urandom};
        mem.resp_valid      = real_resp || spur;
        mem.resp_block_data = rdata;

`ifdef MEM_ARB_RR_EN
        win_d = d_vld && !(i_vld && last_d);
`else
        win_d = d_vld;
`endif
        exp_dr    = !rst_hold && !outstanding && win_d;
        exp_ir    = !rst_hold && !outstanding && i_vld && !win_d;
        exp_iresp = real_resp && !cur.is_d;
        exp_dresp = real_resp && cur.is_d;

        @(negedge clk);
        total++;
        if (icache.req_ready !== exp_ir) begin
            bad++;
            $display("FAIL %s icache_req_ready cyc=%0d got=%b exp=%b", tn, cyc, icache.req_ready, exp_ir);
        end
        total++;
        if (dcache.req_ready !== exp_dr) begin
            bad++;
            $display("FAIL %s dcache_req_ready cyc=%0d got=%b exp=%b", tn, cyc, dcache.req_ready, exp_dr);
        end
        total++;
        if (mem.req_valid !== exp_mv) begin
            bad++;
            $display("FAIL %s mem_req_valid cyc=%0d got=%b exp=%b", tn, cyc, mem.req_valid, exp_mv);
        end
        if (rst_hold || exp_mv) begin
            exp_type = rst_hold ? 1'b0 : cur.wr;
            exp_addr = rst_hold ? '0 : cur.addr;
            exp_data = rst_hold ? '0 : cur.data;
            total++;
            if (mem.req_type !== exp_type || mem.req_block_addr !== exp_addr
                || mem.req_block_data !== exp_data) begin
                bad++;
                $display("FAIL %s mem_req_fields cyc=%0d got=%b/%h/%h exp=%b/%h/%h", tn, cyc,
                         mem.req_type, mem.req_block_addr, mem.req_block_data,
                         exp_type, exp_addr, exp_data);
            end
        end
        total++;
        if (icache.resp_valid !== exp_iresp) begin
            bad++;
            $display("FAIL %s icache_resp_valid cyc=%0d got=%b exp=%b", tn, cyc, icache.resp_valid, exp_iresp);
        end
        total++;
        if (dcache.resp_valid !== exp_dresp) begin
            bad++;
            $display("FAIL %s dcache_resp_valid cyc=%0d got=%b exp=%b", tn, cyc, dcache.resp_valid, exp_dresp);
        end
        if (rst_hold) begin
            total++;
            if (icache.resp_block_data !== '0 || dcache.resp_block_data !== '0) begin
                bad++;
                $display("FAIL %s resp_data_in_reset cyc=%0d got=%h/%h exp=0/0", tn, cyc,
                         icache.resp_block_data, dcache.resp_block_data);
            end
        end
        if (real_resp) begin
            total++;
            if (!cur.is_d && (icache.resp_block_data !== rdata || dcache.resp_block_data !== '0)) begin
                bad++;
                $display("FAIL %s icache_resp_data cyc=%0d got=%h/%h exp=%h/0", tn, cyc,
                         icache.resp_block_data, dcache.resp_block_data, rdata);
            end
            if (cur.is_d && (icache.resp_block_data !== '0 || (!cur.wr && dcache.resp_block_data !== rdata))) begin
                bad++;
                $display("FAIL %s dcache_resp_data cyc=%0d got=%h/%h exp=0/%h", tn, cyc,
                         icache.resp_block_data, dcache.resp_block_data, rdata);
            end
        end

        if (icache.req_ready === 1'b1) ir_seen++;
        if (icache.req_ready === 1'b1 && i_vld) begin obs_cyc.push_back(cyc); obs_d.push_back(1'b0); end
        if (dcache.req_ready === 1'b1 && d_vld) begin obs_cyc.push_back(cyc); obs_d.push_back(1'b1); end
        if (mem.req_valid === 1'b1) mv_seen++;
        if (icache.resp_valid === 1'b1) begin iresp_seen++; last_iresp_cyc = cyc; end
        if (dcache.resp_valid === 1'b1) dresp_seen++;

        @(posedge clk);
        #1;
        if (!rst_hold) begin
            if (real_resp) begin
                outstanding = 1'b0;
                mem_acc     = 1'b0;
                if (cur.wr) store[cur.addr] = cur.data;
            end else if (mem_acc) begin
                lat_left--;
            end
            if (m_rdy) begin
                mem_acc  = 1'b1;
                lat_left = ((lat_cfg < 0) ? int'($urandom_range(1, 4)) : lat_cfg) - 1;
            end else if (exp_mv) begin
                stall_left--;
            end
            if (exp_ir || exp_dr) begin
                outstanding = 1'b1;
                if (exp_dr) begin
                    cur      = d_q.pop_front();
                    cur.is_d = 1'b1;
                end else begin
                    cur.is_d = 1'b0;
                    cur.wr   = 1'b0;
                    cur.addr = i_q.pop_front();
                    cur.data = '0;
                end
                last_d     = exp_dr;
                stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
            end
            i_held = i_vld && !exp_ir;
            d_held = d_vld && !exp_dr;
        end else begin
            i_held = i_vld;
            d_held = d_vld;
        end
        cyc++;
    endtask

    task automatic drain(input string tn, input int budget);
        int n = 0;
        while ((i_q.size() > 0 || d_q.size() > 0 || outstanding) && n < budget) begin
            tick(tn);
            n++;
        end
        if (i_q.size() > 0 || d_q.size() > 0 || outstanding) begin
            total++;
            bad++;
            $display("FAIL %s drain_timeout got=%0d cycles exp=<%0d", tn, n, budget);
        end
    endtask

    task automatic push_d(input logic wr, input addr_t a, input data_t d);
        txn_t t;
        t.is_d = 1'b1;
        t.wr   = wr;
        t.addr = a;
        t.data = wr ? d : '0;
        d_q.push_back(t);
    endtask

    task automatic apply_reset(input string tn);
        rst_hold = 1'b1;
        tick(tn);
        tick(tn);
        rst_hold = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset("reset");
        tick("reset");
        tick("reset");
    endtask

    task automatic test_icache_read();
        int base = obs_cyc.size();
        int mv0 = mv_seen, i0 = iresp_seen, d0 = dresp_seen;
        store[16'h0012] = {8{8'hAB}};
        stall_cfg = 0; lat_cfg = 2; spur_pct = 0; pres_pct = 100;
        i_q.push_back(16'h0012);
        drain("icache_read", 50);
        tick("icache_read");
        total++;
        if (mv_seen - mv0 !== 1) begin
            bad++; $display("FAIL icache_read mem_valid_cycles got=%0d exp=1", mv_seen - mv0);
        end
        total++;
        if (iresp_seen - i0 !== 1 || dresp_seen - d0 !== 0) begin
            bad++; $display("FAIL icache_read resp_counts got=%0d/%0d exp=1/0", iresp_seen - i0, dresp_seen - d0);
        end
        total++;
        if (obs_cyc.size() != base + 1 || last_iresp_cyc - obs_cyc[base] !== 3) begin
            bad++; $display("FAIL icache_read resp_latency got=%0d exp=3", last_iresp_cyc - obs_cyc[base]);
        end
    endtask

    task automatic test_dcache_write();
        int mv0 = mv_seen, d0 = dresp_seen, r0 = ir_seen;
        stall_cfg = 3; lat_cfg = 2; spur_pct = 0; pres_pct = 100;
        push_d(1'b1, 16'h0040, {4{16'h5A5A}});
        drain("dcache_write", 50);
        total++;
        if (mv_seen - mv0 !== 4) begin
            bad++; $display("FAIL dcache_write mem_valid_cycles got=%0d exp=4", mv_seen - mv0);
        end
        total++;
        if (dresp_seen - d0 !== 1 || ir_seen - r0 !== 0) begin
            bad++; $display("FAIL dcache_write ack/iready got=%0d/%0d exp=1/0", dresp_seen - d0, ir_seen - r0);
        end
        stall_cfg = 0; lat_cfg = 1;
        push_d(1'b0, 16'h0040, '0);
        drain("dcache_readback", 50);
    endtask

    task automatic test_conflict();
        bit exp_g [4];
        int base;
`ifdef MEM_ARB_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        apply_reset("conflict");
        base = obs_cyc.size();
        stall_cfg = 0; lat_cfg = 1; spur_pct = 0; pres_pct = 100;
        for (int k = 0; k < 4; k++) begin
            i_q.push_back(addr_t'(16'h0100 + k));
            push_d(1'(k % 2), addr_t'(16'h0200 + k), {$urandom, $urandom});
        end
        drain("conflict", 200);
        total++;
        if (obs_cyc.size() - base !== 8) begin
            bad++; $display("FAIL conflict accept_count got=%0d exp=8", obs_cyc.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (obs_d[base + k] !== exp_g[k]) begin
                    bad++; $display("FAIL conflict grant%0d got_d=%b exp_d=%b", k, obs_d[base + k], exp_g[k]);
                end
            end
        end
    endtask

    task automatic test_spurious();
        int i0 = iresp_seen, d0 = dresp_seen;
        stall_cfg = 2; lat_cfg = 2; spur_pct = 0; pres_pct = 100;
        force_spur = 1'b1;
        tick("spurious");
        force_spur = 1'b1;
        tick("spurious");
        i_q.push_back(16'h0033);
        for (int k = 0; k < 3; k++) begin
            force_spur = 1'b1;
            tick("spurious");
        end
        drain("spurious", 50);
        total++;
        if (iresp_seen - i0 !== 1 || dresp_seen - d0 !== 0) begin
            bad++; $display("FAIL spurious resp_counts got=%0d/%0d exp=1/0", iresp_seen - i0, dresp_seen - d0);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int base, c0;
        int d0 = dresp_seen;
        stall_cfg = 0; lat_cfg = 6; spur_pct = 0; pres_pct = 100;
        push_d(1'b1, 16'h0077, {2{32'hDEAD_BEEF}});
        push_d(1'b0, 16'h0078, '0);
        while (!mem_acc && n < 10) begin
            tick("reset_mid");
            n++;
        end
        rst_hold = 1'b1;
        tick("reset_mid");
        tick("reset_mid");
        rst_hold  = 1'b0;
        stall_cfg = 3;
        lat_cfg   = 1;
        base = obs_cyc.size();
        c0   = cyc;
        tick("reset_mid");
        tick("reset_mid");
        force_spur = 1'b1;
        tick("reset_mid");
        drain("reset_mid", 50);
        total++;
        if (obs_cyc.size() <= base || obs_cyc[base] !== c0) begin
            bad++; $display("FAIL reset_mid first_accept got=%0d exp=%0d",
                            (obs_cyc.size() > base) ? obs_cyc[base] : -1, c0);
        end
        total++;
        if (dresp_seen - d0 !== 1) begin
            bad++; $display("FAIL reset_mid dcache_resp_count got=%0d exp=1", dresp_seen - d0);
        end
    endtask

    task automatic test_back_to_back();
        int base = obs_cyc.size();
        stall_cfg = 0; lat_cfg = 1; spur_pct = 0; pres_pct = 100;
        for (int k = 0; k < 3; k++) i_q.push_back(addr_t'(16'h0500 + k));
        drain("back_to_back", 50);
        total++;
        if (obs_cyc.size() - base !== 3) begin
            bad++; $display("FAIL back_to_back accept_count got=%0d exp=3", obs_cyc.size() - base);
        end else begin
            total++;
            if (obs_cyc[base + 1] - obs_cyc[base] !== 3 || obs_cyc[base + 2] - obs_cyc[base] !== 6) begin
                bad++; $display("FAIL back_to_back accept_spacing got=+%0d,+%0d exp=+3,+6",
                                obs_cyc[base + 1] - obs_cyc[base], obs_cyc[base + 2] - obs_cyc[base]);
            end
        end
    endtask

    task automatic test_random();
        int r0 = iresp_seen + dresp_seen;
        int n_txn = 0;
        stall_cfg = -1; lat_cfg = -1; spur_pct = 20; pres_pct = 60;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) i_q.push_back(addr_t'($urandom_range(0, 7)));
            else push_d(1'($urandom_range(0, 1)), addr_t'($urandom_range(0, 7)), {$urandom, $urandom});
            n_txn++;
        end
        drain("random", 3000);
        total++;
        if (iresp_seen + dresp_seen - r0 !== n_txn) begin
            bad++; $display("FAIL random resp_count got=%0d exp=%0d", iresp_seen + dresp_seen - r0, n_txn);
        end
        spur_pct = 0; pres_pct = 100;
    endtask

    initial begin
        icache.req_valid = 1'b0; icache.req_type = 1'b0;
        icache.req_block_addr = '0; icache.req_block_data = '0;
        dcache.req_valid = 1'b0; dcache.req_type = 1'b0;
        dcache.req_block_addr = '0; dcache.req_block_data = '0;
        mem.req_ready = 1'b0; mem.resp_valid = 1'b0; mem.resp_block_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_conflict();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
